// File: rtl/vtg_register.sv
// Parameterised storage register: write-enabled capture of datain on the rising clock edge,
// asynchronous active-high reset to a per-instance pattern.
module vtg_register #(
    parameter int              SIZE    = 8,
    parameter logic [SIZE-1:0] RST_VAL = {SIZE{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [SIZE-1:0] datain,
    output logic [SIZE-1:0] dataout
);

    generate
        if (SIZE < 1) begin : gen_bad_size
            $fatal(1, "vtg_register: SIZE must be at least 1");
        end
    endgenerate

    logic [SIZE-1:0] data_d;
    logic [SIZE-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (we) begin
            data_d = datain;
        end
    end

    // Each bit maps to a flop with async set or clear chosen by its RST_VAL bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= RST_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign dataout = data_q;

endmodule

// File: tb/tb_vtg_register.sv
// Scoreboard bench for vtg_register: three instances (1, 4, 8 bits) share rst/we; expected
// contents are queued by the driver and compared by independent monitors.
module tb_vtg_register;

    localparam logic       RV1 = 1'b0;
    localparam logic [3:0] RV4 = 4'b1010;
    localparam logic [7:0] RV8 = 8'hA5;

    logic       clk = 1'b0;
    logic       rst;
    logic       we;
    logic       d1;
    logic [3:0] d4;
    logic [7:0] d8;
    logic       q1;
    logic [3:0] q4;
    logic [7:0] q8;

    always #5 clk = ~clk;

    vtg_register #(.SIZE(1), .RST_VAL(RV1)) u_r1 (
        .clk(clk), .rst(rst), .we(we), .datain(d1), .dataout(q1)
    );
    vtg_register #(.SIZE(4), .RST_VAL(RV4)) u_r4 (
        .clk(clk), .rst(rst), .we(we), .datain(d4), .dataout(q4)
    );
    vtg_register #(.SIZE(8), .RST_VAL(RV8)) u_r8 (
        .clk(clk), .rst(rst), .we(we), .datain(d8), .dataout(q8)
    );

    typedef struct packed {
        logic       e1;
        logic [3:0] e4;
        logic [7:0] e8;
    } exp_t;

    exp_t edge_q[$];
    exp_t mid_q[$];
    event mid_ev;
    int   errors = 0;
    int   checks = 0;

    // Reference model: what each register should hold right now.
    logic       m1;
    logic [3:0] m4;
    logic [7:0] m8;

    task automatic check_all(input string tag, input exp_t e);
        checks += 3;
        if (q1 !== e.e1) begin
            errors++;
            $display("FAIL %s r1 @%0t: got %b want %b", tag, $time, q1, e.e1);
        end
        if (q4 !== e.e4) begin
            errors++;
            $display("FAIL %s r4 @%0t: got %b want %b", tag, $time, q4, e.e4);
        end
        if (q8 !== e.e8) begin
            errors++;
            $display("FAIL %s r8 @%0t: got %h want %h", tag, $time, q8, e.e8);
        end
    endtask

    // Monitor after each rising edge: contents produced by that edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (edge_q.size() != 0) check_all("edge", edge_q.pop_front());
        end
    end

    // Monitor between edges: contents must not have moved except through reset.
    initial begin
        forever begin
            @(mid_ev);
            while (mid_q.size() != 0) check_all("mid", mid_q.pop_front());
        end
    end

    task automatic model_reset();
        m1 = RV1;
        m4 = RV4;
        m8 = RV8;
    endtask

    // One clock cycle of stimulus, applied at the falling edge (away from the active edge).
    task automatic drive(input logic r, input logic w, input logic i1, input logic [3:0] i4,
                         input logic [7:0] i8, input bit pulse);
        @(negedge clk);
        rst = r;
        we  = w;
        d1  = i1;
        d4  = i4;
        d8  = i8;
        #1;
        if (r) model_reset();
        mid_q.push_back('{m1, m4, m8});
        ->mid_ev;
        if (pulse) begin
            #1 rst = 1'b1;
            #1;
            model_reset();
            mid_q.push_back('{m1, m4, m8});
            ->mid_ev;
            #1 rst = r;
        end
        if (r) begin
            model_reset();
        end else if (w) begin
            m1 = i1;
            m4 = i4;
            m8 = i8;
        end
        edge_q.push_back('{m1, m4, m8});
    endtask

    initial begin
        rst = 1'b1;
        we  = 1'b0;
        d1  = 1'b0;
        d4  = 4'h0;
        d8  = 8'h00;
        model_reset();

        // Reset held over several edges.
        repeat (4) drive(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
        // Writes, then back-to-back writes.
        drive(1'b0, 1'b1, 1'b1, 4'b0101, 8'h3C, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 4'b1111, 8'hC3, 1'b0);
        // Hold with toggling datain.
        drive(1'b0, 1'b1, 1'b1, 4'b0110, 8'h66, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, i[0], (i[0] ? 4'b1001 : 4'b0000), 8'(i * 37), 1'b0);
        end
        // Async reset pulse between edges, then hold, then write.
        drive(1'b0, 1'b1, 1'b1, 4'b1111, 8'hFF, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 4'b1111, 8'hFF, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 4'b0111, 8'h11, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 4'b0011, 8'h33, 1'b0);
        // Reset priority over write.
        repeat (3) drive(1'b1, 1'b1, 1'b1, 4'b0101, 8'h5A, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 4'b0101, 8'h5A, 1'b0);

        for (int i = 0; i < 80; i++) begin
            logic r;
            r = ($urandom_range(0, 9) == 0);
            drive(r, 1'($urandom_range(0, 1)), 1'($urandom), 4'($urandom), 8'($urandom),
                  (!r && ($urandom_range(0, 7) == 0)));
        end
        drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);

        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (edge_q.size() != 0) begin
            errors++;
            $display("FAIL edge_drain: got %0d pending want 0", edge_q.size());
        end
        checks++;
        if (mid_q.size() != 0) begin
            errors++;
            $display("FAIL mid_drain: got %0d pending want 0", mid_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vtg_register.md
Name: vtg_register

Overview:
- Generic parameterised storage register with write enable and asynchronous reset to a configurable value.
- Basic state-holding building block used throughout the design: pipeline stages, control flags, configuration fields.
- Instantiated at any width from 1 bit upward; each instance may carry its own non-zero reset pattern.

Parameters:
- SIZE, 8, data width in bits; legal range SIZE >= 1; elaboration must fail (error/$fatal) for SIZE < 1.
- RST_VAL, {SIZE{1'b0}}, SIZE-bit value loaded into the register while reset is asserted. Wider values are truncated to the low SIZE bits; narrower values are zero-extended.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- we  input  1  write enable; 1 = capture datain on the next rising clk edge.
- datain  input  SIZE  data to be stored.
- dataout  output  SIZE  current register contents; driven directly from the storage flops, with no combinational path from any input.

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high.
- Reset:
  - Asserting rst forces dataout to RST_VAL immediately, without waiting for a clk edge.
  - dataout stays at RST_VAL for as long as rst is high, regardless of clk, we and datain.
  - Reset has priority over write in every case.
- Write:
  - On a rising clk edge with rst low and we high, datain is captured and dataout equals it after the edge.
  - Latency is 1 clock, measured from datain/we sampled at the edge to the new dataout value.
- Hold: on a rising clk edge with rst low and we low, dataout keeps its previous value.
- Between clock edges, dataout does not change except through rst assertion. Glitches on datain or we between edges have no effect.
- Reset release:
  - rst deasserting between edges leaves dataout at RST_VAL until the first qualifying write edge.
  - If rst falls at a clk edge where we is high, the write is not guaranteed. Integration must release rst away from active clk edges, synchronised by the reset-release logic upstream.
- Reset mid-operation: rst rising at any time, including just after a write edge, overrides the stored value with RST_VAL asynchronously.
- Writing the same value as currently stored is legal and has no observable effect.
- SIZE = 1 is fully supported, with datain, dataout and RST_VAL all 1 bit.
- Initial state before the first reset is undefined (X in simulation). There is no initial block or power-on value; users must assert rst at start-up.
- No X-propagation suppression: an X on datain with we high is stored as X.
- Implementation: single always block sensitive to posedge clk and posedge rst, using non-blocking assignments. Must be synthesisable to SIZE D flip-flops with async preset/clear per bit according to RST_VAL, plus an enable (or feedback mux).

Test Plan:
- Reset values: SIZE=1/RST_VAL=0 and SIZE=4/RST_VAL=4'b1010 instances, rst=1 for several clocks with we=0 and datain=0 -> dataout = 0 and 4'b1010 respectively.
- Write after reset: rst=0, we=1, datain=1 and 4'b0101 -> after the next rising edge, dataout = 1 and 4'b0101. The values must not appear before that edge.
- Back-to-back writes: we held at 1, datain changes to 0 and 4'b1111 -> dataout = 0 and 4'b1111 one edge later, with no intermediate value.
- Hold: load 4'b0110, then we=0 with datain toggling 4'b1001/4'b0000 over 5 clocks -> dataout stays 4'b0110 throughout.
- Asynchronous reset mid-operation: dataout = 4'b1111, pulse rst high between clk edges -> dataout = 4'b1010 immediately, before any clk edge. After release with we=0 it stays 4'b1010; the next write with datain=4'b0011 gives 4'b0011.
- Reset priority: rst=1 and we=1 with datain=4'b0101 across several edges -> dataout remains 4'b1010 (and 0 for the 1-bit instance).
